// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, master IDs and defaults for the bus arbiter
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } arb_state_t;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    localparam int MAX_HOLD_DEFAULT  = 64;
    localparam int CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/arb_hold_counter.sv
// rtl/arb_hold_counter.sv - saturating grant-hold counter with at-limit flag
module arb_hold_counter
    import bus_pkg::*;
#(
    parameter int MAX_HOLD  = MAX_HOLD_DEFAULT,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_HOLD - 1);

    logic [CNT_WIDTH-1:0] count;

    // Count owned cycles; clear wins over enable, and the count parks at LIMIT
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !at_limit) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign at_limit = (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with hold limit and split parking
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_HOLD  = MAX_HOLD_DEFAULT,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic breq1,
    input  logic breq2,
    input  logic ssplit,
    input  logic split_resume,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic split_pend,
    output logic split_id
);

    arb_state_t state;
    arb_state_t state_nxt;

    logic last_grant;
    logic last_grant_nxt;
    logic msel_nxt;
    logic split_pend_nxt;
    logic split_id_nxt;
    // Set once the slave has signalled that the parked master's data is ready
    logic resumed;
    logic resumed_nxt;

    logic at_limit;
    logic cnt_clear;
    logic cnt_enable;

    logic blocked1;
    logic blocked2;
    logic elig1;
    logic elig2;
    logic prio1;
    logic prio2;
    logic parked_req;
    logic split_take;
    logic forfeit;
    logic parked_granted;

    // A parked master stays ineligible until resumed; once resumed it has priority
    assign blocked1   = split_pend && !resumed && (split_id == M1);
    assign blocked2   = split_pend && !resumed && (split_id == M2);
    assign elig1      = breq1 && !blocked1;
    assign elig2      = breq2 && !blocked2;
    assign prio1      = split_pend && resumed && (split_id == M1) && breq1;
    assign prio2      = split_pend && resumed && (split_id == M2) && breq2;
    assign parked_req = (split_id == M1) ? breq1 : breq2;

    // A split only lands on an active owner with no split already outstanding
    assign split_take = ssplit && !split_pend && (state != ST_IDLE);
    assign forfeit    = split_pend && resumed && !parked_req;

    // Next-state arbitration: priority for resumed master, round-robin otherwise
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (prio1) begin
                    state_nxt = ST_GRANT1;
                end else if (prio2) begin
                    state_nxt = ST_GRANT2;
                end else if (elig1 && elig2) begin
                    state_nxt = (last_grant == M1) ? ST_GRANT2 : ST_GRANT1;
                end else if (elig1) begin
                    state_nxt = ST_GRANT1;
                end else if (elig2) begin
                    state_nxt = ST_GRANT2;
                end
            end
            ST_GRANT1: begin
                if (split_take || !breq1) begin
                    state_nxt = elig2 ? ST_GRANT2 : ST_IDLE;
                end else if (at_limit && elig2) begin
                    state_nxt = ST_GRANT2;
                end
            end
            ST_GRANT2: begin
                if (split_take || !breq2) begin
                    state_nxt = elig1 ? ST_GRANT1 : ST_IDLE;
                end else if (at_limit && elig1) begin
                    state_nxt = ST_GRANT1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Split bookkeeping and the mux select / round-robin history that follow the grant
    always_comb begin
        split_pend_nxt = split_pend;
        split_id_nxt   = split_id;
        resumed_nxt    = resumed;
        msel_nxt       = msel;
        last_grant_nxt = last_grant;

        parked_granted = (split_id == M1) ? (state_nxt == ST_GRANT1)
                                          : (state_nxt == ST_GRANT2);

        if (split_take) begin
            split_pend_nxt = 1'b1;
            split_id_nxt   = (state == ST_GRANT2) ? M2 : M1;
            resumed_nxt    = 1'b0;
        end else if (split_pend) begin
            if (split_resume) begin
                resumed_nxt = 1'b1;
            end
            if (forfeit || parked_granted) begin
                split_pend_nxt = 1'b0;
                resumed_nxt    = 1'b0;
            end
        end

        if (state_nxt == ST_GRANT1) begin
            msel_nxt       = M1;
            last_grant_nxt = M1;
        end else if (state_nxt == ST_GRANT2) begin
            msel_nxt       = M2;
            last_grant_nxt = M2;
        end
    end

    // Register arbiter state; reset forgets any split and favours master 1 next
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            msel       <= M1;
            last_grant <= M2;
            split_pend <= 1'b0;
            split_id   <= M1;
            resumed    <= 1'b0;
        end else begin
            state      <= state_nxt;
            msel       <= msel_nxt;
            last_grant <= last_grant_nxt;
            split_pend <= split_pend_nxt;
            split_id   <= split_id_nxt;
            resumed    <= resumed_nxt;
        end
    end

    assign cnt_clear  = (state_nxt != state) || (state == ST_IDLE);
    assign cnt_enable = (state != ST_IDLE);

    arb_hold_counter #(
        .MAX_HOLD  (MAX_HOLD),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .at_limit (at_limit)
    );

    assign bgrant1 = (state == ST_GRANT1);
    assign bgrant2 = (state == ST_GRANT2);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with a cycle model
module tb_bus_arbiter;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic breq1 = 1'b0;
    logic breq2 = 1'b0;
    logic ssplit = 1'b0;
    logic split_resume = 1'b0;
    logic bgrant1;
    logic bgrant2;
    logic msel;
    logic split_pend;
    logic split_id;

    int checks = 0;
    int errors = 0;

    // model: owner 0=none,1,2; held = cycles owned incl. current; parked 0=none,1,2
    int m_owner;
    int m_held;
    int m_parked;
    int m_last;
    bit m_resumed;
    bit m_msel;

    bus_arbiter #(
        .MAX_HOLD  (MH),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .breq1        (breq1),
        .breq2        (breq2),
        .ssplit       (ssplit),
        .split_resume (split_resume),
        .bgrant1      (bgrant1),
        .bgrant2      (bgrant2),
        .msel         (msel),
        .split_pend   (split_pend),
        .split_id     (split_id)
    );

    always #5 clk = ~clk;

    // grants must never overlap
    always @(negedge clk) begin
        checks++;
        if (bgrant1 === 1'b1 && bgrant2 === 1'b1) begin
            errors++;
            $display("FAIL mutex t=%0t got bgrant1=1 bgrant2=1 want not both", $time);
        end
    end

    function automatic bit m_elig(input int n, input bit b1, input bit b2);
        bit req;
        req = (n == 1) ? b1 : b2;
        return req && !(m_parked == n && !m_resumed);
    endfunction

    task automatic model_step(input bit r, input bit b1, input bit b2, input bit ss, input bit sr);
        int nxt_owner;
        int other;
        bit split_now;
        bit preq;
        if (r) begin
            m_owner = 0; m_held = 0; m_parked = 0; m_resumed = 0; m_last = 2; m_msel = 0;
            return;
        end
        nxt_owner = m_owner;
        split_now = ss && (m_parked == 0) && (m_owner != 0);
        if (m_owner == 0) begin
            preq = (m_parked == 1) ? b1 : b2;
            if (m_parked != 0 && m_resumed && preq) nxt_owner = m_parked;
            else if (m_elig(1, b1, b2) && m_elig(2, b1, b2)) nxt_owner = (m_last == 1) ? 2 : 1;
            else if (m_elig(1, b1, b2)) nxt_owner = 1;
            else if (m_elig(2, b1, b2)) nxt_owner = 2;
        end else begin
            other = 3 - m_owner;
            preq = (m_owner == 1) ? b1 : b2;
            if (split_now || !preq) nxt_owner = m_elig(other, b1, b2) ? other : 0;
            else if (m_held >= MH && m_elig(other, b1, b2)) nxt_owner = other;
        end
        if (split_now) begin
            m_parked = m_owner;
            m_resumed = 0;
        end else if (m_parked != 0) begin
            preq = (m_parked == 1) ? b1 : b2;
            if ((m_resumed && !preq) || nxt_owner == m_parked) begin
                m_parked = 0;
                m_resumed = 0;
            end else if (sr) begin
                m_resumed = 1;
            end
        end
        if (nxt_owner != m_owner) m_held = (nxt_owner == 0) ? 0 : 1;
        else if (m_owner != 0) m_held++;
        if (nxt_owner != 0 && nxt_owner != m_owner) begin
            m_last = nxt_owner;
            m_msel = (nxt_owner == 2);
        end
        m_owner = nxt_owner;
    endtask

    task automatic cyc(input bit r, input bit b1, input bit b2, input bit ss, input bit sr);
        rst = r; breq1 = b1; breq2 = b2; ssplit = ss; split_resume = sr;
        model_step(r, b1, b2, ss, sr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel, split_pend, split_id} !== 5'b00000) begin
            errors++;
            $display("FAIL reset got %b want 00000", {bgrant1, bgrant2, msel, split_pend, split_id});
        end
    endtask

    task automatic test_basic_grant();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({bgrant1, bgrant2} !== 2'b00) begin
            errors++; $display("FAIL basic_idle got %b want 00", {bgrant1, bgrant2});
        end
        cyc(0, 1, 0, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel} !== 3'b100) begin
            errors++; $display("FAIL basic_grant got %b want 100", {bgrant1, bgrant2, msel});
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel} !== 3'b000) begin
            errors++; $display("FAIL basic_release got %b want 000", {bgrant1, bgrant2, msel});
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel} !== 3'b100) begin
            errors++; $display("FAIL rr_first got %b want 100", {bgrant1, bgrant2, msel});
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel} !== 3'b011) begin
            errors++; $display("FAIL rr_handoff got %b want 011", {bgrant1, bgrant2, msel});
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel} !== 3'b001) begin
            errors++; $display("FAIL rr_idle_msel got %b want 001", {bgrant1, bgrant2, msel});
        end
        cyc(0, 1, 1, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel} !== 3'b100) begin
            errors++; $display("FAIL rr_turn got %b want 100", {bgrant1, bgrant2, msel});
        end
    endtask

    task automatic test_hold_limit();
        int n;
        int guard;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        n = 1;
        guard = 0;
        while (guard < 12) begin
            cyc(0, 1, 1, 0, 0);
            guard++;
            if (bgrant1 === 1'b1) n++;
            else break;
        end
        checks++;
        if (n != MH || {bgrant2, msel} !== 2'b11) begin
            errors++;
            $display("FAIL hold_limit got cycles=%0d g2msel=%b want cycles=%0d g2msel=11", n, {bgrant2, msel}, MH);
        end
        cyc(1, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (bgrant1 === 1'b1) n++;
        end
        checks++;
        if (n != 24) begin
            errors++; $display("FAIL hold_alone got %0d granted cycles want 24", n);
        end
    endtask

    task automatic test_split();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        checks++;
        if ({bgrant1, bgrant2, msel, split_pend, split_id} !== 5'b01110) begin
            errors++;
            $display("FAIL split_park got %b want 01110", {bgrant1, bgrant2, msel, split_pend, split_id});
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, split_pend} !== 3'b011) begin
            errors++; $display("FAIL split_blocked got %b want 011", {bgrant1, bgrant2, split_pend});
        end
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 0, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel, split_pend} !== 4'b1000) begin
            errors++; $display("FAIL split_resume got %b want 1000", {bgrant1, bgrant2, msel, split_pend});
        end
    endtask

    task automatic test_split_same_cycle();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        checks++;
        if ({bgrant1, bgrant2, split_pend, split_id} !== 4'b1011) begin
            errors++; $display("FAIL split2_park got %b want 1011", {bgrant1, bgrant2, split_pend, split_id});
        end
        cyc(0, 1, 1, 1, 0);
        checks++;
        if ({bgrant1, bgrant2, split_pend, split_id} !== 4'b1011) begin
            errors++; $display("FAIL split2_second got %b want 1011", {bgrant1, bgrant2, split_pend, split_id});
        end
        cyc(0, 1, 1, 1, 1);
        checks++;
        if ({bgrant1, bgrant2, split_pend, split_id} !== 4'b1011) begin
            errors++; $display("FAIL split2_both got %b want 1011", {bgrant1, bgrant2, split_pend, split_id});
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel, split_pend} !== 4'b0110) begin
            errors++; $display("FAIL split2_resumed got %b want 0110", {bgrant1, bgrant2, msel, split_pend});
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(1, 1, 1, 0, 0);
        checks++;
        if ({bgrant1, bgrant2, msel, split_pend, split_id} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid got %b want 00000", {bgrant1, bgrant2, msel, split_pend, split_id});
        end
    endtask

    task automatic test_random();
        bit b1;
        bit b2;
        bit r;
        logic [3:0] exp;
        b1 = 0;
        b2 = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) b1 = ~b1;
            if ($urandom_range(0, 3) == 0) b2 = ~b2;
            r = ($urandom_range(0, 99) == 0);
            cyc(r, b1, b2, $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0);
            exp = {m_owner == 1, m_owner == 2, m_msel, m_parked != 0};
            checks++;
            if ({bgrant1, bgrant2, msel, split_pend} !== exp) begin
                errors++;
                $display("FAIL rand cycle %0d got g1g2mselsp=%b want %b", i, {bgrant1, bgrant2, msel, split_pend}, exp);
            end
            if (m_parked != 0) begin
                checks++;
                if (split_id !== (m_parked == 2)) begin
                    errors++;
                    $display("FAIL rand_split_id cycle %0d got %b want %b", i, split_id, m_parked == 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_back_to_back();
        test_hold_limit();
        test_split();
        test_split_same_cycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, 64, max grant cycles while the other master waits (range 2..255).
REQ-002 Parameter CNT_WIDTH, 8, hold-counter width; SHALL satisfy 2^CNT_WIDTH > MAX_HOLD.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 breq1  input  1  master 1 bus request, level, held for whole transaction.
REQ-006 breq2  input  1  master 2 bus request, level.
REQ-007 ssplit  input  1  one-cycle pulse from serial slave: split current owner's transaction.
REQ-008 split_resume  input  1  one-cycle pulse from slave: split data ready, parked master may resume.
REQ-009 bgrant1  output  1  master 1 owns bus (registered).
REQ-010 bgrant2  output  1  master 2 owns bus (registered).
REQ-011 msel  output  1  bus mux select, 0 = master 1, 1 = master 2; holds last owner when idle.
REQ-012 split_pend  output  1  a master is parked on a split.
REQ-013 split_id  output  1  parked master, 0 = master 1, 1 = master 2; valid only when split_pend=1.

Function
REQ-014 FSM states IDLE, GRANT1, GRANT2; bgrant1=1 only in GRANT1, bgrant2=1 only in GRANT2; never both high.
REQ-015 Eligible master: breqN=1 and not (split_pend=1 and split_id=N).
REQ-016 IDLE: one eligible -> grant it; both eligible -> grant the master not granted last (round-robin, last_grant register); grant visible cycle after request sampled (1-cycle latency).
REQ-017 GRANTn: held while breqn=1, ssplit=0, hold limit not reached.
REQ-018 GRANTn with breqn=0: other master eligible -> direct handoff to GRANTother next cycle; else IDLE.
REQ-019 Hold counter clears on every grant change, increments each GRANTn cycle, saturates at MAX_HOLD-1.
REQ-020 Counter = MAX_HOLD-1 and other master eligible -> handoff next cycle; other not eligible -> owner keeps bus, no release.
REQ-021 ssplit=1 in GRANTn with split_pend=0 -> split_pend=1, split_id=n, grant dropped next cycle, then as REQ-018 with master n ineligible.
REQ-022 ssplit with split_pend=1, or in IDLE -> ignored, no state change.
REQ-023 split_resume=1 with split_pend=1 -> parked master becomes eligible with absolute priority at next arbitration point; no preemption of current owner except via REQ-020.
REQ-024 split_pend clears the cycle the parked master is granted; split_resume with split_pend=0 ignored.
REQ-025 ssplit and split_resume same cycle with split_pend=1 -> resume applies, ssplit ignored.
REQ-026 Parked master's breq dropping after resume -> priority forfeited, split_pend cleared.
REQ-027 msel updates together with the grant, never mid-grant.

Reset
REQ-028 rst=1 at a clock edge -> IDLE, bgrant1=0, bgrant2=0, msel=0, split_pend=0, split_id=0, counter=0, last_grant=master 2 (master 1 first); mid-transaction reset drops grants next edge and discards any split.

Structure
REQ-029 Shared package bus_pkg holds the FSM state encoding, master ID constants (M1=0, M2=1) and the MAX_HOLD default.
REQ-030 Hold counter SHALL be one sub-module, arb_hold_counter (clear, enable, saturate, at-limit flag); remainder in bus_arbiter.

Verification
REQ-031 Reset, breq1=1 one cycle later -> bgrant1=1 exactly one cycle after breq1 sampled, msel=0.
REQ-032 breq1=breq2=1 from IDLE after reset -> bgrant1 first; drop breq1 -> bgrant2=1 next cycle, msel=1, no idle gap.
REQ-033 MAX_HOLD=4, breq1 held, breq2 raised at grant cycle 1 -> bgrant1 falls after 4 grant cycles, bgrant2=1; breq2 absent -> bgrant1 held 20+ cycles.
REQ-034 GRANT1, ssplit pulse, breq2=1 -> split_pend=1, split_id=0, bgrant2=1 next cycle; breq1 ignored until split_resume; after resume and breq2 drop -> bgrant1=1, split_pend=0.
REQ-035 ssplit and split_resume same cycle while parked -> split_id unchanged, resume honoured; second ssplit while parked -> no effect.
REQ-036 rst asserted during GRANT2 with split pending -> all outputs at reset values next edge; every cycle checks bgrant1 & bgrant2 = 0.
